alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// Two-entry in-order ALU result buffer with committed {N,Z,V,C} flags; one-cycle push-to-output latency.
// InReady is a register (low only when FULL); optional overflow counter enabled by ALU_RESULT_OVFCNT_EN.
module alu_result_buffer #(
  parameter int RD_W = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [15:0]     InResult,
  input  logic            InZero,
  input  logic            InOverflow,
  input  logic            InCarryOut,
  input  logic [3:0]      InOp,
  input  logic [RD_W-1:0] InRd,
  input  logic            InFlagWe,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [15:0]     OutResult,
  output logic [RD_W-1:0] OutRd,
  output logic [3:0]      Flags
`ifdef ALU_RESULT_OVFCNT_EN
  ,
  output logic [7:0]      OvfCount
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0]     result;
    logic [RD_W-1:0] rd;
    logic            zero;
    logic            ovf;
    logic            carry;
    logic [2:0]      op;
    logic            flag_we;
  } entry_t;

  state_t state;
  entry_t head_q;
  entry_t tail_q;
  entry_t in_entry;
  logic   push;
  logic   pop;
  logic   head_is_add;
  logic   unused_op_msb;

  // Only Op[2:0] decides whether V/C are architecturally meaningful.
  always_comb begin
    in_entry         = '0;
    in_entry.result  = InResult;
    in_entry.rd      = InRd;
    in_entry.zero    = InZero;
    in_entry.ovf     = InOverflow;
    in_entry.carry   = InCarryOut;
    in_entry.op      = InOp[2:0];
    in_entry.flag_we = InFlagWe;
  end

  assign unused_op_msb = InOp[3];

  assign push        = InValid & InReady;
  assign pop         = OutValid & OutReady;
  assign head_is_add = (head_q.op == 3'b100);

  assign OutResult = head_q.result;
  assign OutRd     = head_q.rd;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      Flags    <= 4'b0000;
`ifdef ALU_RESULT_OVFCNT_EN
      OvfCount <= 8'h00;
`endif
    end else begin
      // Flags commit with the head entry as it leaves the buffer.
      if (pop && head_q.flag_we) begin
        Flags[3] <= head_q.result[15];
        Flags[2] <= head_q.zero;
        if (head_is_add) begin
          Flags[1] <= head_q.ovf;
          Flags[0] <= head_q.carry;
        end
      end
`ifdef ALU_RESULT_OVFCNT_EN
      if (pop && head_is_add && head_q.ovf && (OvfCount != 8'hFF)) begin
        OvfCount <= OvfCount + 8'd1;
      end
`endif
      case (state)
        EMPTY: begin
          if (push) begin
            head_q   <= in_entry;
            state    <= ONE;
            OutValid <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_q  <= in_entry;
            state   <= FULL;
            InReady <= 1'b0;
          end else if (!push && pop) begin
            state    <= EMPTY;
            OutValid <= 1'b0;
          end else if (push && pop) begin
            head_q <= in_entry;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state   <= ONE;
            InReady <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
